adc_acq_sequencer: RTL and testbench

ADC_ACQ_SEQUENCER -- requirements
Module: adc_acq_sequencer

---
 rtl/adc_acq_pkg.sv | 23 ++
 rtl/adc_acq_out_reg.sv | 58 +++++
 rtl/adc_acq_sequencer.sv | 158 +++++++++++++++
 tb/tb_adc_acq_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_acq_pkg.sv
// Shared types and constants for the ADC acquisition sequencer.
package adc_acq_pkg;

    localparam int SAMPLE_W           = 16;
    localparam int SEQ_W              = 16;
    localparam int CNT_W              = 16;
    localparam int DATA_W             = SEQ_W + SAMPLE_W;
    localparam int DEFAULT_MIN_PERIOD = 25;
    localparam int DEFAULT_TIMEOUT    = 255;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_DATA,
        GAP,
        DONE
    } acq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/adc_acq_out_reg.sv
// Single-entry valid/ready output register; a load that finds the entry
// occupied and not draining is dropped and latches the sticky overrun flag.
module adc_acq_out_reg
    import adc_acq_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear_flags,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              overrun_q, overrun_d;

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        // A word leaving in the same cycle frees the slot for the new one.
        if (load) begin
            if (!valid_q || ready) begin
                data_d  = load_data;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clear_flags) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data    = data_q;
    assign valid   = valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/adc_acq_sequencer.sv
// Acquisition sequencer: paces AD7985 conversion triggers, tags each result
// with a sequence number and hands it to the output register.
module adc_acq_sequencer
    import adc_acq_pkg::*;
#(
    parameter int               MIN_PERIOD = DEFAULT_MIN_PERIOD,
    parameter int               TIMEOUT    = DEFAULT_TIMEOUT,
    parameter logic [SEQ_W-1:0] SEQ_INIT   = '0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                iAcqStart,
    input  logic                iAcqStop,
    input  logic [CNT_W-1:0]    iSamplePeriod,
    input  logic [CNT_W-1:0]    iSampleCount,
    output logic                oAdcStart,
    input  logic [SAMPLE_W-1:0] iAdcData,
    input  logic                iAdcData_en,
    output logic [DATA_W-1:0]   oData,
    output logic                oDataValid,
    input  logic                iDataReady,
    output logic                oBusy,
    output logic                oDone,
    output logic                oOverrun,
    output logic                oTimeout
);

    localparam logic [CNT_W-1:0] MIN_PERIOD_C = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W-1:0] TIMEOUT_C    = CNT_W'(TIMEOUT);

    acq_state_t       state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             stop_q, stop_d;
    logic             timeout_q, timeout_d;
    logic             run_start;
    logic             capture;
    logic             taken;
    logic             last_sample;

    assign last_sample = (count_q != '0) && (sample_cnt_q == count_q);

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        count_d       = count_q;
        period_cnt_d  = sat_inc(period_cnt_q);
        timeout_cnt_d = sat_inc(timeout_cnt_q);
        sample_cnt_d  = sample_cnt_q;
        seq_d         = seq_q;
        stop_d        = stop_q;
        timeout_d     = timeout_q;
        run_start     = 1'b0;
        capture       = 1'b0;
        taken         = 1'b0;

        if (iAcqStop && (state_q != IDLE)) begin
            stop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (iAcqStart) begin
                    period_d     = (iSamplePeriod < MIN_PERIOD_C) ? MIN_PERIOD_C : iSamplePeriod;
                    count_d      = iSampleCount;
                    seq_d        = SEQ_INIT;
                    sample_cnt_d = '0;
                    timeout_d    = 1'b0;
                    stop_d       = 1'b0;
                    run_start    = 1'b1;
                    state_d      = TRIG;
                end
            end
            TRIG: begin
                state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (iAdcData_en) begin
                    capture = 1'b1;
                    taken   = 1'b1;
                end else if (timeout_cnt_q >= TIMEOUT_C) begin
                    timeout_d = 1'b1;
                    taken     = 1'b1;
                end
                // Lost samples still consume a sequence number.
                if (taken) begin
                    seq_d        = seq_q + 1'b1;
                    sample_cnt_d = sat_inc(sample_cnt_q);
                    state_d      = GAP;
                end
            end
            GAP: begin
                if (period_cnt_q >= period_q - 1'b1) begin
                    state_d = (last_sample || stop_q || iAcqStop) ? DONE : TRIG;
                end
            end
            DONE: begin
                stop_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Both counters read 0 during the trigger cycle itself.
        if (state_d == TRIG) begin
            period_cnt_d  = '0;
            timeout_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            period_q      <= '0;
            count_q       <= '0;
            period_cnt_q  <= '0;
            timeout_cnt_q <= '0;
            sample_cnt_q  <= '0;
            seq_q         <= '0;
            stop_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            count_q       <= count_d;
            period_cnt_q  <= period_cnt_d;
            timeout_cnt_q <= timeout_cnt_d;
            sample_cnt_q  <= sample_cnt_d;
            seq_q         <= seq_d;
            stop_q        <= stop_d;
            timeout_q     <= timeout_d;
        end
    end

    adc_acq_out_reg u_out_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear_flags (run_start),
        .load        (capture),
        .load_data   ({seq_q, iAdcData}),
        .ready       (iDataReady),
        .data        (oData),
        .valid       (oDataValid),
        .overrun     (oOverrun)
    );

    assign oAdcStart = (state_q == TRIG);
    assign oBusy     = (state_q != IDLE);
    assign oDone     = (state_q == DONE);
    assign oTimeout  = timeout_q;

endmodule

// File: tb/tb_adc_acq_sequencer.sv
// Self-checking bench for adc_acq_sequencer: an ADC model answers triggers and
// expected trigger times and words come from period/latency arithmetic.
module tb_adc_acq_sequencer;

    localparam int MIN_P = 25;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        iAcqStart = 1'b0;
    logic        iAcqStop = 1'b0;
    logic [15:0] iSamplePeriod = 16'd0;
    logic [15:0] iSampleCount = 16'd0;
    logic [15:0] iAdcData = 16'd0;
    logic        iAdcData_en = 1'b0;
    logic        iDataReady = 1'b0;

    logic        oAdcStart, oDataValid, oBusy, oDone, oOverrun, oTimeout;
    logic [31:0] oData;
    logic        wAdcStart, wDataValid, wBusy, wDone, wOverrun, wTimeout;
    logic [31:0] wData;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int          trigQ[$];
    int          doneQ[$];
    logic [31:0] wordQ[$];
    logic [31:0] wrapQ[$];
    logic [15:0] adcDataQ[$];

    int adcLatency = 22;
    int adcSkip = -1;
    int adcTrigNum = 0;
    int injectReq = 0;
    int injectDone = 0;
    int adcN;

    adc_acq_sequencer dut (
        .clk(clk), .reset_n(reset_n), .iAcqStart(iAcqStart), .iAcqStop(iAcqStop),
        .iSamplePeriod(iSamplePeriod), .iSampleCount(iSampleCount), .oAdcStart(oAdcStart),
        .iAdcData(iAdcData), .iAdcData_en(iAdcData_en), .oData(oData), .oDataValid(oDataValid),
        .iDataReady(iDataReady), .oBusy(oBusy), .oDone(oDone), .oOverrun(oOverrun),
        .oTimeout(oTimeout)
    );

    adc_acq_sequencer #(.SEQ_INIT(16'hFFFE)) dutWrap (
        .clk(clk), .reset_n(reset_n), .iAcqStart(iAcqStart), .iAcqStop(iAcqStop),
        .iSamplePeriod(iSamplePeriod), .iSampleCount(iSampleCount), .oAdcStart(wAdcStart),
        .iAdcData(iAdcData), .iAdcData_en(iAdcData_en), .oData(wData), .oDataValid(wDataValid),
        .iDataReady(iDataReady), .oBusy(wBusy), .oDone(wDone), .oOverrun(wOverrun),
        .oTimeout(wTimeout)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the DUT mid-cycle: triggers, accepted words and done pulses.
    always @(negedge clk) begin
        if (oAdcStart) trigQ.push_back(cyc);
        if (oDone) doneQ.push_back(cyc);
        if (oDataValid && iDataReady) wordQ.push_back(oData);
        if (wDataValid && iDataReady) wrapQ.push_back(wData);
    end

    // ADC model: strobes random data adcLatency clocks after each trigger.
    initial begin
        forever begin
            @(negedge clk);
            if (injectReq != injectDone) begin
                injectDone = injectReq;
                @(posedge clk); #1;
                iAdcData = 16'($urandom);
                iAdcData_en = 1'b1;
                @(posedge clk); #1;
                iAdcData_en = 1'b0;
            end else if (oAdcStart) begin
                adcN = adcTrigNum;
                adcTrigNum = adcTrigNum + 1;
                if (adcN != adcSkip) begin
                    repeat (adcLatency) @(posedge clk);
                    #1;
                    iAdcData = 16'($urandom);
                    iAdcData_en = 1'b1;
                    adcDataQ.push_back(iAdcData);
                    @(posedge clk); #1;
                    iAdcData_en = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic startRun(input int p, input int c, input bit withStop);
        tick();
        iSamplePeriod = 16'(p);
        iSampleCount = 16'(c);
        iAcqStart = 1'b1;
        iAcqStop = withStop;
        tick();
        iAcqStart = 1'b0;
        iAcqStop = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit ok);
        int d0;
        d0 = doneQ.size();
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk); #1;
            if (doneQ.size() > d0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        total++;
        if ({oAdcStart, oDataValid, oBusy, oDone, oOverrun, oTimeout} !== 6'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b expected 000000",
                     {oAdcStart, oDataValid, oBusy, oDone, oOverrun, oTimeout});
        end
        total++;
        if (oData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got %h expected 00000000", oData);
        end
        total++;
        if ({wData, wAdcStart, wDataValid, wBusy, wDone, wOverrun, wTimeout} !== 38'h0) begin
            bad++;
            $display("[TB] FAIL reset_wrap: got %h expected 0",
                     {wData, wAdcStart, wDataValid, wBusy, wDone, wOverrun, wTimeout});
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_timed_runs();
        int pTab[8];
        int cTab[8];
        int lTab[8];
        int peff, space, t0, w0, a0, d0, nTrig, nWord;
        bit ok;
        logic [31:0] expWord;
        pTab[0] = 40; cTab[0] = 3; lTab[0] = 22;
        pTab[1] = 10; cTab[1] = 3; lTab[1] = 8;
        pTab[2] = 30; cTab[2] = 2; lTab[2] = 28;
        pTab[3] = 30; cTab[3] = 2; lTab[3] = 29;
        for (int i = 4; i < 8; i++) begin
            pTab[i] = $urandom_range(60, 1);
            peff = (pTab[i] < MIN_P) ? MIN_P : pTab[i];
            cTab[i] = $urandom_range(4, 1);
            lTab[i] = $urandom_range(peff + 3, 3);
        end
        for (int r = 0; r < 8; r++) begin
            peff = (pTab[r] < MIN_P) ? MIN_P : pTab[r];
            space = (peff > lTab[r] + 2) ? peff : lTab[r] + 2;
            t0 = trigQ.size(); w0 = wordQ.size(); a0 = adcDataQ.size(); d0 = doneQ.size();
            adcLatency = lTab[r];
            iDataReady = 1'b1;
            startRun(pTab[r], cTab[r], r == 0);
            waitDone(cTab[r] * space + 100, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("[TB] FAIL run%0d_done: got none expected pulse", r);
            end
            nTrig = trigQ.size() - t0;
            total++;
            if (nTrig != cTab[r]) begin
                bad++;
                $display("[TB] FAIL run%0d_trig_count: got %0d expected %0d", r, nTrig, cTab[r]);
            end else begin
                for (int k = 1; k < nTrig; k++) begin
                    total++;
                    if (trigQ[t0 + k] - trigQ[t0 + k - 1] != space) begin
                        bad++;
                        $display("[TB] FAIL run%0d_spacing%0d: got %0d expected %0d", r, k,
                                 trigQ[t0 + k] - trigQ[t0 + k - 1], space);
                    end
                end
                if (ok) begin
                    total++;
                    if (doneQ[d0] - trigQ[t0 + nTrig - 1] != space) begin
                        bad++;
                        $display("[TB] FAIL run%0d_done_time: got %0d expected %0d", r,
                                 doneQ[d0] - trigQ[t0 + nTrig - 1], space);
                    end
                end
            end
            @(negedge clk); #1;
            nWord = wordQ.size() - w0;
            total++;
            if (nWord != cTab[r] || adcDataQ.size() - a0 < nWord) begin
                bad++;
                $display("[TB] FAIL run%0d_word_count: got %0d expected %0d", r, nWord, cTab[r]);
            end else begin
                for (int k = 0; k < nWord; k++) begin
                    expWord = {16'(k), adcDataQ[a0 + k]};
                    total++;
                    if (wordQ[w0 + k] !== expWord) begin
                        bad++;
                        $display("[TB] FAIL run%0d_word%0d: got %h expected %h", r, k,
                                 wordQ[w0 + k], expWord);
                    end
                end
            end
            total++;
            if ({oBusy, oDone, oOverrun, oTimeout} !== 4'b0) begin
                bad++;
                $display("[TB] FAIL run%0d_idle_flags: got %b expected 0000", r,
                         {oBusy, oDone, oOverrun, oTimeout});
            end
        end
    endtask

    task automatic test_overrun();
        int t0, w0, a0;
        bit ok;
        logic [31:0] expWord;
        t0 = trigQ.size(); w0 = wordQ.size(); a0 = adcDataQ.size();
        adcLatency = 10;
        iDataReady = 1'b0;
        startRun(30, 4, 1'b0);
        repeat (40) tick();
        iAcqStart = 1'b1;
        iSampleCount = 16'd1;
        tick();
        iAcqStart = 1'b0;
        waitDone(400, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL ovr_done: got none expected pulse");
        end
        total++;
        if (trigQ.size() - t0 != 4) begin
            bad++;
            $display("[TB] FAIL ovr_trig_count: got %0d expected 4", trigQ.size() - t0);
        end
        expWord = (adcDataQ.size() > a0) ? {16'h0000, adcDataQ[a0]} : 32'hxxxxxxxx;
        total++;
        if ({oOverrun, oDataValid} !== 2'b11 || oData !== expWord) begin
            bad++;
            $display("[TB] FAIL ovr_held: got ovr=%b valid=%b data=%h expected 1 1 %h",
                     oOverrun, oDataValid, oData, expWord);
        end
        tick();
        iDataReady = 1'b1;
        @(negedge clk); #1;
        total++;
        if (wordQ.size() - w0 != 1 || wordQ[w0] !== expWord) begin
            bad++;
            $display("[TB] FAIL ovr_release: got %0d words expected 1 word %h",
                     wordQ.size() - w0, expWord);
        end
        @(negedge clk); #1;
        total++;
        if ({oDataValid, oOverrun} !== 2'b01) begin
            bad++;
            $display("[TB] FAIL ovr_after: got valid=%b ovr=%b expected 0 1", oDataValid, oOverrun);
        end
    endtask

    task automatic test_timeout();
        int t0, w0, a0;
        bit ok;
        logic [31:0] exp0, exp2;
        t0 = trigQ.size(); w0 = wordQ.size(); a0 = adcDataQ.size();
        adcLatency = 10;
        adcSkip = adcTrigNum + 1;
        iDataReady = 1'b1;
        startRun(30, 3, 1'b0);
        waitDone(1000, ok);
        adcSkip = -1;
        total++;
        if (!ok || oTimeout !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tmo_flag: got done=%b tmo=%b expected 1 1", ok, oTimeout);
        end
        total++;
        if (trigQ.size() - t0 != 3) begin
            bad++;
            $display("[TB] FAIL tmo_trig_count: got %0d expected 3", trigQ.size() - t0);
        end else begin
            total++;
            if (trigQ[t0 + 1] - trigQ[t0] != 30 || trigQ[t0 + 2] - trigQ[t0 + 1] != TMO + 2) begin
                bad++;
                $display("[TB] FAIL tmo_spacing: got %0d,%0d expected 30,%0d",
                         trigQ[t0 + 1] - trigQ[t0], trigQ[t0 + 2] - trigQ[t0 + 1], TMO + 2);
            end
        end
        @(negedge clk); #1;
        total++;
        if (wordQ.size() - w0 != 2 || adcDataQ.size() - a0 != 2) begin
            bad++;
            $display("[TB] FAIL tmo_word_count: got %0d expected 2", wordQ.size() - w0);
        end else begin
            exp0 = {16'd0, adcDataQ[a0]};
            exp2 = {16'd2, adcDataQ[a0 + 1]};
            total++;
            if (wordQ[w0] !== exp0 || wordQ[w0 + 1] !== exp2) begin
                bad++;
                $display("[TB] FAIL tmo_words: got %h,%h expected %h,%h",
                         wordQ[w0], wordQ[w0 + 1], exp0, exp2);
            end
        end
    endtask

    task automatic test_stop_wrap();
        int t0, w0, r0, a0, d0;
        bit ok, seen;
        logic [31:0] expWord, expWrap;
        t0 = trigQ.size(); w0 = wordQ.size(); r0 = wrapQ.size();
        a0 = adcDataQ.size(); d0 = doneQ.size();
        adcLatency = 15;
        iDataReady = 1'b1;
        startRun(30, 0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (trigQ.size() - t0 == 4) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL stop_fourth_trig: got %0d triggers expected 4", trigQ.size() - t0);
        end
        repeat (5) @(negedge clk);
        tick();
        iAcqStop = 1'b1;
        tick();
        iAcqStop = 1'b0;
        waitDone(200, ok);
        repeat (100) @(negedge clk);
        #1;
        total++;
        if (!ok || trigQ.size() - t0 != 4 || doneQ.size() - d0 != 1) begin
            bad++;
            $display("[TB] FAIL stop_end: got trig=%0d done=%0d expected 4 1",
                     trigQ.size() - t0, doneQ.size() - d0);
        end else begin
            total++;
            if (doneQ[d0] - trigQ[t0 + 3] != 30) begin
                bad++;
                $display("[TB] FAIL stop_done_time: got %0d expected 30", doneQ[d0] - trigQ[t0 + 3]);
            end
        end
        total++;
        if (wordQ.size() - w0 != 4 || wrapQ.size() - r0 != 4 || adcDataQ.size() - a0 != 4) begin
            bad++;
            $display("[TB] FAIL stop_word_count: got %0d/%0d expected 4/4",
                     wordQ.size() - w0, wrapQ.size() - r0);
        end else begin
            for (int k = 0; k < 4; k++) begin
                expWord = {16'(k), adcDataQ[a0 + k]};
                expWrap = {16'(32'hFFFE + k), adcDataQ[a0 + k]};
                total++;
                if (wordQ[w0 + k] !== expWord || wrapQ[r0 + k] !== expWrap) begin
                    bad++;
                    $display("[TB] FAIL stop_word%0d: got %h/%h expected %h/%h", k,
                             wordQ[w0 + k], wrapQ[r0 + k], expWord, expWrap);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0, t1;
        bit seen, leak;
        t0 = trigQ.size();
        adcLatency = 22;
        iDataReady = 1'b0;
        startRun(40, 5, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (trigQ.size() > t0) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("[TB] FAIL rst_trig: got none expected trigger");
        end
        repeat (30) @(negedge clk);
        #1;
        total++;
        if ({oBusy, oDataValid} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL rst_pre: got busy=%b valid=%b expected 1 1", oBusy, oDataValid);
        end
        tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({oAdcStart, oDataValid, oBusy, oDone, oOverrun, oTimeout} !== 6'b0 || oData !== 32'h0) begin
            bad++;
            $display("[TB] FAIL rst_mid: got flags=%b data=%h expected 000000 00000000",
                     {oAdcStart, oDataValid, oBusy, oDone, oOverrun, oTimeout}, oData);
        end
        iDataReady = 1'b1;
        t1 = trigQ.size();
        injectReq = injectReq + 1;
        leak = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (oDataValid || oBusy) leak = 1'b1;
        end
        #1;
        total++;
        if (leak || trigQ.size() != t1) begin
            bad++;
            $display("[TB] FAIL rst_late_strobe: got leak=%b trig=%0d expected 0 0",
                     leak, trigQ.size() - t1);
        end
    endtask

    initial begin
        test_reset();
        test_timed_runs();
        test_overrun();
        test_timeout();
        test_stop_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
